// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that loads a seed into a shift-or-reload LFSR and streams exactly N samples.
// First sample 3 cycles after start; a stall reloads the seed and replays emitted steps.
module lfsr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_sel,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             err_seed
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    STALL = 3'd3,
    SKIP  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] seed_reg;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] emitted;
  logic [CNT_W-1:0] emitted_inc;
  logic [CNT_W-1:0] skip_cnt;
  logic             slot_free;
  logic             hs;
  logic             accept;
  logic             capture;
  logic             arm_skip;
  logic             done_set;
  logic             err_set;

  assign slot_free   = !out_valid || out_ready;
  assign hs          = out_valid && out_ready;
  assign emitted_inc = emitted + CNT_W'(1);
  assign lfsr_seed   = seed_reg;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_sel  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    arm_skip  = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (seed_in == '0) begin
            err_set = 1'b1;
          end else if (num_steps == '0) begin
            done_set = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (slot_free) begin
          lfsr_sel = 1'b1;
          capture  = 1'b1;
          if (emitted_inc == total) begin
            state_nxt = DRAIN;
          end
        end else begin
          // The LFSR cannot hold, so it falls back to the seed and progress is replayed later.
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (slot_free) begin
          arm_skip  = 1'b1;
          state_nxt = SKIP;
        end
      end
      SKIP: begin
        lfsr_sel = 1'b1;
        if (skip_cnt == CNT_W'(1)) begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (hs) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      seed_reg  <= '0;
      total     <= '0;
      emitted   <= '0;
      skip_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      err_seed  <= 1'b0;
    end else begin
      done     <= done_set;
      err_seed <= err_set;
      if (accept) begin
        seed_reg <= seed_in;
        total    <= num_steps;
        emitted  <= '0;
      end
      if (capture) begin
        out_data  <= lfsr_q;
        out_valid <= 1'b1;
        emitted   <= emitted_inc;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      // Replay length equals the samples already produced, so SKIP restores the LFSR position.
      if (arm_skip) begin
        skip_cnt <= emitted;
      end else if (state == SKIP) begin
        skip_cnt <= skip_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: attaches a shift-or-reload LFSR and scores the stream against
// the sequence a free-running LFSR produces from the same seed.
module tb_lfsr_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic [WIDTH-1:0] seed_in;
  logic [CNT_W-1:0] num_steps;
  logic [WIDTH-1:0] lfsr_q;
  logic             lfsr_sel;
  logic [WIDTH-1:0] lfsr_seed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             err_seed;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  int valid_cnt, sel_cnt, busy_cnt, done_cnt, err_cnt;
  int done_cyc, err_cyc, first_valid_cyc;
  logic [WIDTH-1:0] got[$];

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .start(start), .seed_in(seed_in), .num_steps(num_steps),
    .lfsr_q(lfsr_q), .lfsr_sel(lfsr_sel), .lfsr_seed(lfsr_seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err_seed(err_seed)
  );

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  // Sample k of a run: the seed advanced k-1 times.
  function automatic logic [WIDTH-1:0] gold(input logic [WIDTH-1:0] seed, input int k);
    logic [WIDTH-1:0] q;
    q = seed;
    for (int i = 1; i < k; i++) q = lfsr_step(q);
    return q;
  endfunction

  always @(posedge clk) begin
    if (res) lfsr_q <= '0;
    else if (lfsr_sel) lfsr_q <= lfsr_step(lfsr_q);
    else lfsr_q <= lfsr_seed;
  end

  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) got.push_back(out_data);
    if (out_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (lfsr_sel) sel_cnt++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err_seed) begin err_cnt++; err_cyc = cyc; end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    valid_cnt = 0; sel_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    done_cyc = -1; err_cyc = -1; first_valid_cyc = -1;
    got.delete();
  endtask

  task automatic issue(input logic [WIDTH-1:0] seed, input logic [CNT_W-1:0] n);
    seed_in = seed; num_steps = n; start = 1'b1;
    t0 = cyc + 1;
    tick();
    start = 1'b0;
    seed_in = 4'($urandom);
    num_steps = 8'($urandom);
  endtask

  task automatic test_reset();
    res = 1'b1; start = 1'b0; seed_in = '0; num_steps = '0; out_ready = 1'b1;
    tick(); tick();
    res = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_busy_valid: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    checks++;
    if (done !== 1'b0 || err_seed !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: done=%b err_seed=%b want 0 0", done, err_seed);
    end
    checks++;
    if (lfsr_sel !== 1'b0 || lfsr_seed !== 4'h0 || out_data !== 4'h0) begin
      failures++;
      $display("FAIL reset_data: sel=%b seed=%h data=%h want 0 0 0", lfsr_sel, lfsr_seed, out_data);
    end
  endtask

  task automatic test_basic(input logic [WIDTH-1:0] seed, input int n);
    int bad, first_bad;
    clear_mon();
    out_ready = 1'b1;
    issue(seed, 8'(n));
    for (int i = 0; i < n + 20 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt);
    end
    checks++;
    if (done_cyc !== t0 + n + 3) begin
      failures++; $display("FAIL basic_done_cycle: got t+%0d want t+%0d", done_cyc - t0, n + 3);
    end
    checks++;
    if (first_valid_cyc !== t0 + 3) begin
      failures++; $display("FAIL basic_latency: got t+%0d want t+3", first_valid_cyc - t0);
    end
    checks++;
    if (valid_cnt !== n || sel_cnt !== n || busy_cnt !== n + 2) begin
      failures++;
      $display("FAIL basic_counts: valid=%0d sel=%0d busy=%0d want %0d %0d %0d",
               valid_cnt, sel_cnt, busy_cnt, n, n, n + 2);
    end
    bad = 0; first_bad = -1;
    for (int k = 0; k < n; k++) begin
      if (k >= got.size() || got[k] !== gold(seed, k + 1)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    checks++;
    if (bad != 0 || got.size() != n) begin
      failures++;
      $display("FAIL basic_samples: %0d bad (first idx %0d), got %0d samples want %0d",
               bad, first_bad, got.size(), n);
    end
  endtask

  task automatic test_mid_skip_reset();
    bit found;
    clear_mon();
    out_ready = 1'b0;
    issue(4'($urandom_range(1, 15)), 8'd10);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (busy && out_valid && !lfsr_sel) found = 1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    if (found) begin
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (busy && lfsr_sel && !out_valid) found = 1;
      end
    end
    res = 1'b1;
    tick();
    res = 1'b0;
    checks++;
    if (!found) begin
      failures++; $display("FAIL midskip_reach: stall/skip not observed found=%0d want 1", found);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || lfsr_sel !== 1'b0 || out_data !== 4'h0) begin
      failures++;
      $display("FAIL midskip_reset: busy=%b valid=%b sel=%b data=%h want 0 0 0 0",
               busy, out_valid, lfsr_sel, out_data);
    end
    test_basic(4'($urandom_range(1, 15)), 7);
  endtask

  task automatic test_stall();
    int bad, low, skip_exp, n;
    bit dropped;
    logic [WIDTH-1:0] seed;
    seed = 4'b1001; n = 6;
    clear_mon();
    out_ready = 1'b1;
    issue(seed, 8'(n));
    dropped = 0; low = 0; skip_exp = 0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      if (!dropped && got.size() == 1) begin
        // Sample 2 is on the bus, so two steps are lost when the consumer stalls now.
        dropped = 1; low = 3; skip_exp = got.size() + 1;
      end
      out_ready = (low == 0);
      if (low > 0) low--;
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (sel_cnt !== n + skip_exp || skip_exp != 2) begin
      failures++; $display("FAIL stall_sel_cycles: got %0d want %0d", sel_cnt, n + 2);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt);
    end
    bad = 0;
    for (int k = 0; k < n; k++)
      if (k >= got.size() || got[k] !== gold(seed, k + 1)) bad++;
    checks++;
    if (bad != 0 || got.size() != n) begin
      failures++;
      $display("FAIL stall_samples: %0d bad, got %0d samples want %0d", bad, got.size(), n);
    end
  endtask

  task automatic test_err();
    clear_mon();
    out_ready = 1'b1;
    issue(4'h0, 8'd4);
    repeat (5) tick();
    checks++;
    if (err_cnt !== 1 || err_cyc !== t0 + 1) begin
      failures++; $display("FAIL err_pulse: count=%0d at t+%0d want 1 at t+1", err_cnt, err_cyc - t0);
    end
    checks++;
    if (busy_cnt !== 0 || valid_cnt !== 0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL err_quiet: busy=%0d valid=%0d done=%0d want 0 0 0", busy_cnt, valid_cnt, done_cnt);
    end
  endtask

  task automatic test_zero();
    clear_mon();
    out_ready = 1'b1;
    issue(4'b0110, 8'd0);
    repeat (5) tick();
    checks++;
    if (done_cnt !== 1 || done_cyc !== t0 + 1) begin
      failures++; $display("FAIL zero_done: count=%0d at t+%0d want 1 at t+1", done_cnt, done_cyc - t0);
    end
    checks++;
    if (busy_cnt !== 0 || valid_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL zero_quiet: busy=%0d valid=%0d err=%0d want 0 0 0", busy_cnt, valid_cnt, err_cnt);
    end
  endtask

  task automatic test_toggle();
    int bad, n;
    logic [WIDTH-1:0] seed;
    seed = 4'($urandom_range(1, 15)); n = 255;
    clear_mon();
    out_ready = 1'b1;
    issue(seed, 8'(n));
    for (int i = 0; i < 60000 && done_cnt == 0; i++) begin
      out_ready = ~out_ready;
      if (got.size() < n - 3 && $urandom_range(0, 15) == 0) begin
        start = 1'b1; seed_in = 4'($urandom); num_steps = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      failures++; $display("FAIL toggle_done: done=%0d err=%0d want 1 0", done_cnt, err_cnt);
    end
    bad = 0;
    for (int k = 0; k < n; k++)
      if (k >= got.size() || got[k] !== gold(seed, k + 1)) bad++;
    checks++;
    if (bad != 0 || got.size() != n) begin
      failures++;
      $display("FAIL toggle_samples: %0d bad, got %0d samples want %0d", bad, got.size(), n);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL toggle_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_random();
    int bad, n;
    logic [WIDTH-1:0] seed;
    for (int r = 0; r < 6; r++) begin
      seed = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 40);
      clear_mon();
      out_ready = 1'b1;
      issue(seed, 8'(n));
      for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      out_ready = 1'b1;
      repeat (3) tick();
      bad = 0;
      for (int k = 0; k < n; k++)
        if (k >= got.size() || got[k] !== gold(seed, k + 1)) bad++;
      checks++;
      if (bad != 0 || got.size() != n || done_cnt != 1) begin
        failures++;
        $display("FAIL random_run%0d: seed=%h n=%0d bad=%0d samples=%0d done=%0d want 0 %0d 1",
                 r, seed, n, bad, got.size(), done_cnt, n);
      end
    end
  endtask

  initial begin
    res = 1'b1; start = 1'b0; seed_in = '0; num_steps = '0; out_ready = 1'b0;
    clear_mon();
    test_reset();
    test_mid_skip_reset();
    test_basic(4'b1001, 5);
    test_stall();
    test_err();
    test_zero();
    test_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
